wb_unified_mem_arbiter: RTL and testbench

Two-master Wishbone classic arbiter that shares one unified memory port between the core's instruction bus (iwb) and data bus (dwb). It sits between `custom_riscv_core` and the single-array code+data memory, so self-modifying code and FENCE.I see one coherent store. It performs round-robin arbitration, holds the grant for a whole transaction, and terminates hung transactions with a bus error after a programmable timeout.

---
 rtl/wb_unified_mem_arbiter_pkg.sv | 10 +
 rtl/wb_timeout_counter.sv | 19 +
 rtl/wb_unified_mem_arbiter.sv | 85 ++++++++
 tb/tb_wb_unified_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_unified_mem_arbiter_pkg.sv
// wb_unified_mem_arbiter_pkg: arbiter state encodings and grant bit indices
package wb_unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_BUSY = 2'd1,
    ARB_D_BUSY = 2'd2
  } arb_state_e;
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;
endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: counts enabled cycles and flags the cycle that reaches limit
module wb_timeout_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
  // the limit-th enabled cycle since clear is the expiring one; limit 0 never expires
  assign expired_o = enable_i && (limit_i != '0) && (cnt_q == limit_i - 1'b1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// wb_unified_mem_arbiter: round-robin iwb/dwb arbiter onto one unified Wishbone memory port
module wb_unified_mem_arbiter
  import wb_unified_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic [31:0] mwb_adr_o,
  output logic [31:0] mwb_dat_o,
  output logic        mwb_we_o,
  output logic [3:0]  mwb_sel_o,
  output logic        mwb_cyc_o,
  output logic        mwb_stb_o,
  input  logic [31:0] mwb_dat_i,
  input  logic        mwb_ack_i,
  input  logic        mwb_err_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  arb_state_e state_q;
  logic last_d_q;
  logic i_req, d_req, own_i, own_d, busy, owner_cyc, slv_ack, slv_err, cnt_en, tmo, done;
  assign i_req     = iwb_cyc_i && iwb_stb_i;
  assign d_req     = dwb_cyc_i && dwb_stb_i;
  assign own_i     = state_q == ARB_I_BUSY;
  assign own_d     = state_q == ARB_D_BUSY;
  assign busy      = own_i || own_d;
  assign owner_cyc = own_i ? iwb_cyc_i : own_d && dwb_cyc_i;
  assign slv_ack   = owner_cyc && mwb_ack_i && !mwb_err_i;
  assign slv_err   = owner_cyc && mwb_err_i;
  assign cnt_en    = owner_cyc && !mwb_ack_i && !mwb_err_i;
  assign done      = !owner_cyc || slv_ack || slv_err || tmo;
  wb_timeout_counter #(.CNT_W(CNT_W)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!busy),
    .enable_i  (cnt_en),
    .limit_i   (LIMIT),
    .expired_o (tmo)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      last_d_q <= 1'b1;
    end else if (state_q == ARB_IDLE) begin
      state_q <= (i_req && (!d_req || last_d_q)) ? ARB_I_BUSY : d_req ? ARB_D_BUSY : ARB_IDLE;
    end else if (done) begin
      state_q  <= ARB_IDLE;
      last_d_q <= own_d;
    end
  assign iwb_dat_o = mwb_dat_i;
  assign dwb_dat_o = mwb_dat_i;
  assign iwb_ack_o = own_i && slv_ack;
  assign dwb_ack_o = own_d && slv_ack;
  assign iwb_err_o = own_i && (slv_err || tmo);
  assign dwb_err_o = own_d && (slv_err || tmo);
  assign timeout_o = tmo;
  // an aborting owner no longer drives the slave, so a late ack is simply dropped
  assign mwb_cyc_o = owner_cyc && !tmo;
  assign mwb_stb_o = owner_cyc && !tmo;
  assign mwb_adr_o = own_i ? iwb_adr_i : own_d ? dwb_adr_i : '0;
  assign mwb_dat_o = own_d ? dwb_dat_i : '0;
  assign mwb_we_o  = own_d && dwb_we_i;
  assign mwb_sel_o = own_i ? 4'hF : own_d ? dwb_sel_i : 4'h0;
  assign grant_o[GNT_I] = own_i;
  assign grant_o[GNT_D] = own_d;
endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// tb_wb_unified_mem_arbiter: scoreboard bench with a one-cycle-latency memory slave model
module tb_wb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] iwb_adr_i, iwb_dat_o, dwb_adr_i, dwb_dat_i, dwb_dat_o;
  logic iwb_cyc_i, iwb_stb_i, iwb_ack_o, iwb_err_o;
  logic dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
  logic [3:0] dwb_sel_i, mwb_sel_o;
  logic [31:0] mwb_adr_o, mwb_dat_o, mwb_dat_i;
  logic mwb_we_o, mwb_cyc_o, mwb_stb_o, mwb_ack_i, mwb_err_i, timeout_o;
  logic [1:0] grant_o;
  typedef struct packed {logic is_d; logic err; logic chk; logic [31:0] dat;} exp_t;
  exp_t sb[$];
  int pass_cnt = 0, total_cnt = 0;
  logic [31:0] mem [0:255];
  logic ack_q;
  int s_mode = 0;
  always #5 clk = ~clk;
  wb_unified_mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i),
    .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .mwb_adr_o(mwb_adr_o), .mwb_dat_o(mwb_dat_o), .mwb_we_o(mwb_we_o), .mwb_sel_o(mwb_sel_o),
    .mwb_cyc_o(mwb_cyc_o), .mwb_stb_o(mwb_stb_o),
    .mwb_dat_i(mwb_dat_i), .mwb_ack_i(mwb_ack_i), .mwb_err_i(mwb_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );
  // slave: s_mode 0 acks one cycle after stb, 1 never responds, 2 raises ack and err together
  assign mwb_dat_i = mem[mwb_adr_o[9:2]];
  assign mwb_ack_i = ack_q && s_mode != 1;
  assign mwb_err_i = ack_q && s_mode == 2;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_q <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else begin
      ack_q <= mwb_cyc_o && mwb_stb_o && !ack_q;
      if (mwb_ack_i && !mwb_err_i && mwb_cyc_o && mwb_we_o)
        for (int b = 0; b < 4; b++)
          if (mwb_sel_o[b]) mem[mwb_adr_o[9:2]][8*b+:8] <= mwb_dat_o[8*b+:8];
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // waits for any termination and scores it against the oldest expectation
  task automatic collect(output int n);
    exp_t e;
    logic gi, gd, ge;
    logic [31:0] dat;
    n = 0; gi = 0; gd = 0; ge = 0; dat = '0;
    while (n < 20 && !(gi || gd)) begin
      @(negedge clk);
      n++;
      gi = iwb_ack_o || iwb_err_o;
      gd = dwb_ack_o || dwb_err_o;
      ge = iwb_err_o || dwb_err_o;
      dat = gd ? dwb_dat_o : iwb_dat_o;
    end
    total_cnt++;
    if (!(gi || gd)) $display("FAIL collect: no ack/err within 20 cycles");
    else if (sb.size() == 0) $display("FAIL collect: unexpected termination i=%0b d=%0b", gi, gd);
    else begin
      e = sb.pop_front();
      if ({gd, gi, ge} !== {e.is_d, !e.is_d, e.err} || (e.chk && dat !== e.dat))
        $display("FAIL scoreboard: got d=%0b i=%0b err=%0b dat=%h want d=%0b err=%0b dat=%h",
                 gd, gi, ge, dat, e.is_d, e.err, e.dat);
      else pass_cnt++;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant_o); else pass_cnt++;
    total_cnt++; if ({mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o, mwb_dat_o} !== '0)
      $display("FAIL reset_mwb: got cyc=%b stb=%b adr=%h want all 0", mwb_cyc_o, mwb_stb_o, mwb_adr_o); else pass_cnt++;
    total_cnt++; if ({iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o, timeout_o} !== 5'b0)
      $display("FAIL reset_resp: got %b want 00000", {iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o, timeout_o}); else pass_cnt++;
    total_cnt++; if (iwb_dat_o !== 32'hC0DE0000) $display("FAIL reset_dat: got %h want c0de0000", iwb_dat_o); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single_fetch();
    int n;
    iwb_adr_i = 32'h100; iwb_cyc_i = 1; iwb_stb_i = 1;
    sb.push_back({1'b0, 1'b0, 1'b1, 32'hC0DE0040});
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL fetch_grant: got %b want 01", grant_o); else pass_cnt++;
    total_cnt++; if ({mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o} !== {1'b1, 1'b0, 4'hF, 32'h100})
      $display("FAIL fetch_route: got stb=%b we=%b sel=%h adr=%h", mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o); else pass_cnt++;
    collect(n);
    total_cnt++; if (n !== 1) $display("FAIL fetch_latency: got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (dwb_ack_o !== 1'b0) $display("FAIL fetch_dwb_ack: got %b want 0", dwb_ack_o); else pass_cnt++;
    @(posedge clk); #1 iwb_cyc_i = 0; iwb_stb_i = 0;
    @(negedge clk);
    total_cnt++; if ({grant_o, iwb_ack_o} !== 3'b000) $display("FAIL fetch_end: got grant=%b ack=%b want 00 0", grant_o, iwb_ack_o); else pass_cnt++;
  endtask
  task automatic test_tie();
    int n;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    iwb_adr_i = 32'h104; iwb_cyc_i = 1; iwb_stb_i = 1;
    dwb_adr_i = 32'h208; dwb_we_i = 0; dwb_sel_i = 4'hF; dwb_cyc_i = 1; dwb_stb_i = 1;
    sb.push_back({1'b0, 1'b0, 1'b1, 32'hC0DE0041});
    sb.push_back({1'b1, 1'b0, 1'b1, 32'hC0DE0082});
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL tie1_grant: got %b want 01", grant_o); else pass_cnt++;
    collect(n);
    @(posedge clk); #1 iwb_cyc_i = 0; iwb_stb_i = 0;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL tie1_idle: got %b want 00", grant_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b10) $display("FAIL tie2_grant: got %b want 10", grant_o); else pass_cnt++;
    collect(n);
    @(posedge clk); #1 iwb_adr_i = 32'h10C; iwb_cyc_i = 1; iwb_stb_i = 1;
    sb.push_back({1'b0, 1'b0, 1'b1, 32'hC0DE0043});
    sb.push_back({1'b1, 1'b0, 1'b1, 32'hC0DE0082});
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL tie2_idle: got %b want 00", grant_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL tie3_grant: got %b want 01", grant_o); else pass_cnt++;
    collect(n);
    @(posedge clk); #1 iwb_cyc_i = 0; iwb_stb_i = 0;
    collect(n);
    total_cnt++; if (n !== 3) $display("FAIL tie_back_to_back: got %0d want 3", n); else pass_cnt++;
    @(posedge clk); #1 dwb_cyc_i = 0; dwb_stb_i = 0;
    @(negedge clk);
  endtask
  task automatic test_masked_write();
    int n;
    dwb_adr_i = 32'h200; dwb_dat_i = 32'hAABBCCDD; dwb_we_i = 1; dwb_sel_i = 4'b0100;
    dwb_cyc_i = 1; dwb_stb_i = 1;
    sb.push_back({1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    total_cnt++; if ({grant_o, mwb_we_o, mwb_sel_o, mwb_dat_o, mwb_adr_o} !== {2'b10, 1'b1, 4'b0100, 32'hAABBCCDD, 32'h200})
      $display("FAIL write_route: got g=%b we=%b sel=%b dat=%h adr=%h", grant_o, mwb_we_o, mwb_sel_o, mwb_dat_o, mwb_adr_o); else pass_cnt++;
    collect(n);
    total_cnt++; if ({iwb_ack_o, iwb_err_o} !== 2'b00) $display("FAIL write_iwb: got %b want 00", {iwb_ack_o, iwb_err_o}); else pass_cnt++;
    @(posedge clk); #1 dwb_cyc_i = 0; dwb_stb_i = 0; dwb_we_i = 0; dwb_sel_i = 4'hF;
    @(negedge clk);
    total_cnt++; if (mem[8'h80] !== 32'hC0BB0080) $display("FAIL write_mem: got %h want c0bb0080", mem[8'h80]); else pass_cnt++;
  endtask
  task automatic test_timeout();
    int n;
    s_mode = 1;
    dwb_adr_i = 32'h204; dwb_cyc_i = 1; dwb_stb_i = 1;
    sb.push_back({1'b1, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    iwb_adr_i = 32'h108; iwb_cyc_i = 1; iwb_stb_i = 1;
    sb.push_back({1'b0, 1'b0, 1'b1, 32'hC0DE0042});
    total_cnt++; if ({grant_o, timeout_o} !== 3'b100) $display("FAIL tmo_start: got g=%b t=%b want 10 0", grant_o, timeout_o); else pass_cnt++;
    collect(n);
    total_cnt++; if (n !== 3) $display("FAIL tmo_cycle: got %0d want 3", n); else pass_cnt++;
    total_cnt++; if ({timeout_o, dwb_err_o, mwb_cyc_o, mwb_stb_o} !== 4'b1100)
      $display("FAIL tmo_flags: got %b want 1100", {timeout_o, dwb_err_o, mwb_cyc_o, mwb_stb_o}); else pass_cnt++;
    @(posedge clk); #1 dwb_cyc_i = 0; dwb_stb_i = 0; s_mode = 0;
    @(negedge clk);
    total_cnt++; if ({grant_o, timeout_o} !== 3'b000) $display("FAIL tmo_idle: got g=%b t=%b want 00 0", grant_o, timeout_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL tmo_next_grant: got %b want 01", grant_o); else pass_cnt++;
    collect(n);
    @(posedge clk); #1 iwb_cyc_i = 0; iwb_stb_i = 0;
    @(negedge clk);
  endtask
  task automatic test_err_precedence();
    int n;
    s_mode = 2;
    dwb_adr_i = 32'h20C; dwb_cyc_i = 1; dwb_stb_i = 1;
    sb.push_back({1'b1, 1'b1, 1'b0, 32'h0});
    collect(n);
    total_cnt++; if ({dwb_ack_o, dwb_err_o, timeout_o} !== 3'b010)
      $display("FAIL err_prec: got ack=%b err=%b t=%b want 0 1 0", dwb_ack_o, dwb_err_o, timeout_o); else pass_cnt++;
    @(posedge clk); #1 dwb_cyc_i = 0; dwb_stb_i = 0; s_mode = 0;
    @(negedge clk);
  endtask
  task automatic test_abort();
    int n;
    dwb_adr_i = 32'h210; dwb_cyc_i = 1; dwb_stb_i = 1;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b10) $display("FAIL abort_grant: got %b want 10", grant_o); else pass_cnt++;
    @(posedge clk); #1 dwb_cyc_i = 0; dwb_stb_i = 0;
    @(negedge clk);
    total_cnt++; if ({dwb_ack_o, dwb_err_o} !== 2'b00) $display("FAIL abort_resp: got %b want 00", {dwb_ack_o, dwb_err_o}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL abort_idle: got %b want 00", grant_o); else pass_cnt++;
    iwb_adr_i = 32'h114; iwb_cyc_i = 1; iwb_stb_i = 1; dwb_cyc_i = 1; dwb_stb_i = 1;
    sb.push_back({1'b0, 1'b0, 1'b1, 32'hC0DE0045});
    sb.push_back({1'b1, 1'b0, 1'b1, 32'hC0DE0084});
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL abort_last_d: got %b want 01", grant_o); else pass_cnt++;
    collect(n);
    @(posedge clk); #1 iwb_cyc_i = 0; iwb_stb_i = 0;
    collect(n);
    @(posedge clk); #1 dwb_cyc_i = 0; dwb_stb_i = 0;
    @(negedge clk);
  endtask
  task automatic test_async_reset();
    int n;
    dwb_adr_i = 32'h220; dwb_dat_i = 32'h12345678; dwb_we_i = 1; dwb_sel_i = 4'hF;
    dwb_cyc_i = 1; dwb_stb_i = 1;
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b10) $display("FAIL areset_busy: got %b want 10", grant_o); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({grant_o, mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o, mwb_dat_o} !== '0)
      $display("FAIL areset_mwb: got g=%b cyc=%b we=%b sel=%h", grant_o, mwb_cyc_o, mwb_we_o, mwb_sel_o); else pass_cnt++;
    total_cnt++; if ({iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o, timeout_o} !== 5'b0)
      $display("FAIL areset_resp: got %b want 00000", {iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o, timeout_o}); else pass_cnt++;
    dwb_cyc_i = 0; dwb_stb_i = 0; dwb_we_i = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (mem[8'h88] !== 32'hC0DE0088) $display("FAIL areset_lost_write: got %h want c0de0088", mem[8'h88]); else pass_cnt++;
    iwb_adr_i = 32'h118; iwb_cyc_i = 1; iwb_stb_i = 1;
    dwb_adr_i = 32'h224; dwb_cyc_i = 1; dwb_stb_i = 1;
    sb.push_back({1'b0, 1'b0, 1'b1, 32'hC0DE0046});
    sb.push_back({1'b1, 1'b0, 1'b1, 32'hC0DE0089});
    @(negedge clk);
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL areset_tie: got %b want 01", grant_o); else pass_cnt++;
    collect(n);
    @(posedge clk); #1 iwb_cyc_i = 0; iwb_stb_i = 0;
    collect(n);
    @(posedge clk); #1 dwb_cyc_i = 0; dwb_stb_i = 0;
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    iwb_adr_i = '0; iwb_cyc_i = 0; iwb_stb_i = 0;
    dwb_adr_i = '0; dwb_dat_i = '0; dwb_we_i = 0; dwb_sel_i = 4'hF; dwb_cyc_i = 0; dwb_stb_i = 0;
    test_reset();
    test_single_fetch();
    test_tie();
    test_masked_write();
    test_timeout();
    test_err_precedence();
    test_abort();
    test_async_reset();
    total_cnt++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
